// File: rtl/clken_gen_if.sv
// Configuration and output bundle for clken_gen.
// The master side (system / bench) drives config writes and observes the
// per-channel enables, square waves and status flags.
interface clken_gen_if #(
   parameter int unsigned NUM_CH = 7,
   parameter int unsigned DIV_W  = 8
);
   localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              cfg_we;
   logic [ChW-1:0]    cfg_ch;
   logic [DIV_W-1:0]  cfg_div;
   logic [DIV_W-1:0]  cfg_phase;
   logic              cfg_busy;
   logic [NUM_CH-1:0] clken;
   logic [NUM_CH-1:0] clk_level;
   logic              locked;

   modport master (
      output cfg_we, cfg_ch, cfg_div, cfg_phase,
      input  cfg_busy, clken, clk_level, locked
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_div, cfg_phase,
      output cfg_busy, clken, clk_level, locked
   );
endinterface

// File: rtl/clken_gen.sv
// clken_gen: NUM_CH programmable clock-enable / square-wave generators running off refclk.
// Each channel counts 0..D-1; clken pulses at cnt==P and clk_level is high for the first
// ceil(D/2) cycles starting at P. Config writes are parked in a pending register and
// applied only when the counter wraps, so periods are never truncated.
// Optional feature: define CLKEN_GEN_RESYNC_EN to add resync_i, which forces all
// counters to wrap together on the following cycle.
module clken_gen #(
   parameter int unsigned               NUM_CH      = 7,
   parameter int unsigned               DIV_W       = 8,
   parameter logic [NUM_CH*DIV_W-1:0]   DIV_INIT    = {NUM_CH{8'd4}},
   parameter logic [NUM_CH*DIV_W-1:0]   PHASE_INIT  = {NUM_CH{8'd0}},
   parameter int unsigned               LOCK_CYCLES = 16
) (
   input  logic        refclk_i,
   input  logic        rst_i,
`ifdef CLKEN_GEN_RESYNC_EN
   input  logic        resync_i,
`endif
   clken_gen_if.slave  cfg_if
);
   localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned LkW = $clog2(LOCK_CYCLES + 1);
   localparam logic [LkW-1:0] LockMax = LkW'(LOCK_CYCLES);

   logic [DIV_W-1:0]  cnt_q  [NUM_CH];
   logic [DIV_W-1:0]  cnt_d  [NUM_CH];
   logic [DIV_W-1:0]  div_q  [NUM_CH];
   logic [DIV_W-1:0]  div_d  [NUM_CH];
   logic [DIV_W-1:0]  phs_q  [NUM_CH];
   logic [DIV_W-1:0]  phs_d  [NUM_CH];
   logic [DIV_W-1:0]  pdiv_q [NUM_CH];
   logic [DIV_W-1:0]  pdiv_d [NUM_CH];
   logic [DIV_W-1:0]  pphs_q [NUM_CH];
   logic [DIV_W-1:0]  pphs_d [NUM_CH];
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] clken_q, clken_d;
   logic [NUM_CH-1:0] level_q, level_d;
   logic [LkW-1:0]    lock_cnt_q, lock_cnt_d;
   logic              busy_q, busy_d;
   logic              locked_q, locked_d;
   logic              resync;
   logic              wr_ok;
   logic              any_apply;

   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
      return (d == '0) ? DIV_W'(1) : d;
   endfunction

   function automatic logic [DIV_W-1:0] eff_phase(input logic [DIV_W-1:0] d,
                                                   input logic [DIV_W-1:0] p);
      logic [DIV_W-1:0] de;
      de = eff_div(d);
      return (p > de - DIV_W'(1)) ? de - DIV_W'(1) : p;
   endfunction

   // Square-wave level for a given count: ((cnt - P) mod D) < ceil(D/2)
   function automatic logic level_of(input logic [DIV_W-1:0] cnt,
                                     input logic [DIV_W-1:0] d,
                                     input logic [DIV_W-1:0] p);
      logic [DIV_W:0] de, pe, c, diff, half;
      de   = {1'b0, eff_div(d)};
      pe   = {1'b0, eff_phase(d, p)};
      c    = {1'b0, cnt};
      diff = (c >= pe) ? c - pe : c + de - pe;
      half = (de + (DIV_W+1)'(1)) >> 1;
      return diff < half;
   endfunction

   // Next count, config apply/park, and outputs precomputed from the next state
   always_comb begin
      resync = 1'b0;
`ifdef CLKEN_GEN_RESYNC_EN
      resync = resync_i;
`endif
      wr_ok     = cfg_if.cfg_we && (32'(cfg_if.cfg_ch) < NUM_CH);
      any_apply = 1'b0;
      pend_d    = pend_q;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]  = cnt_q[i] + DIV_W'(1);
         div_d[i]  = div_q[i];
         phs_d[i]  = phs_q[i];
         pdiv_d[i] = pdiv_q[i];
         pphs_d[i] = pphs_q[i];
         if (resync || (cnt_q[i] >= eff_div(div_q[i]) - DIV_W'(1))) begin
            cnt_d[i] = '0;
            // A write arriving on the wrap itself bypasses the pending register
            if (wr_ok && (cfg_if.cfg_ch == ChW'(i))) begin
               div_d[i]  = cfg_if.cfg_div;
               phs_d[i]  = cfg_if.cfg_phase;
               pend_d[i] = 1'b0;
            end else if (pend_q[i]) begin
               div_d[i]  = pdiv_q[i];
               phs_d[i]  = pphs_q[i];
               pend_d[i] = 1'b0;
               any_apply = 1'b1;
            end
         end else if (wr_ok && (cfg_if.cfg_ch == ChW'(i))) begin
            pdiv_d[i] = cfg_if.cfg_div;
            pphs_d[i] = cfg_if.cfg_phase;
            pend_d[i] = 1'b1;
         end
         clken_d[i] = (cnt_d[i] == eff_phase(div_d[i], phs_d[i]));
         level_d[i] = level_of(cnt_d[i], div_d[i], phs_d[i]);
      end

      lock_cnt_d = lock_cnt_q;
      if (wr_ok || any_apply || resync) begin
         lock_cnt_d = '0;
      end else if (!busy_q && (lock_cnt_q != LockMax)) begin
         lock_cnt_d = lock_cnt_q + LkW'(1);
      end
      busy_d   = |pend_d;
      locked_d = (lock_cnt_d == LockMax);
   end

   // State and output registers; reset preloads the cycle-0 output values
   always_ff @(posedge refclk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]   <= '0;
            div_q[i]   <= DIV_INIT[i*DIV_W +: DIV_W];
            phs_q[i]   <= PHASE_INIT[i*DIV_W +: DIV_W];
            pdiv_q[i]  <= '0;
            pphs_q[i]  <= '0;
            clken_q[i] <= (eff_phase(DIV_INIT[i*DIV_W +: DIV_W],
                                     PHASE_INIT[i*DIV_W +: DIV_W]) == '0);
            level_q[i] <= level_of('0, DIV_INIT[i*DIV_W +: DIV_W],
                                   PHASE_INIT[i*DIV_W +: DIV_W]);
         end
         pend_q     <= '0;
         lock_cnt_q <= '0;
         busy_q     <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]  <= cnt_d[i];
            div_q[i]  <= div_d[i];
            phs_q[i]  <= phs_d[i];
            pdiv_q[i] <= pdiv_d[i];
            pphs_q[i] <= pphs_d[i];
         end
         pend_q     <= pend_d;
         clken_q    <= clken_d;
         level_q    <= level_d;
         lock_cnt_q <= lock_cnt_d;
         busy_q     <= busy_d;
         locked_q   <= locked_d;
      end
   end

   // Flops hold the cycle-0 values during reset, so outputs are masked while rst_i is high
   assign cfg_if.clken     = rst_i ? '0   : clken_q;
   assign cfg_if.clk_level = rst_i ? '0   : level_q;
   assign cfg_if.cfg_busy  = rst_i ? 1'b0 : busy_q;
   assign cfg_if.locked    = rst_i ? 1'b0 : locked_q;
endmodule
